// File: rtl/gfx_pkg.sv
// Shared types and helpers for the chart sequencer and note lanes.
package gfx_pkg;

    localparam logic [1:0] NOTE_NONE = 2'b00;
    localparam logic [1:0] NOTE_TAIL = 2'b01;
    localparam logic [1:0] NOTE_HEAD = 2'b10;

    localparam int unsigned MAX_WORD_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY,
        S_PAUSED,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // Lane k code of a chart word; the reserved code 11 reads as no note.
    function automatic logic [1:0] chart_lane_code(input logic [MAX_WORD_W-1:0] word,
                                                   input int unsigned k);
        logic [MAX_WORD_W-1:0] shifted;
        logic [1:0] code;
        shifted = word >> (2 * k);
        code = shifted[1:0];
        case (code)
            NOTE_HEAD, NOTE_TAIL: return code;
            default:              return NOTE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/chart_sequencer_if.sv
// Chart ROM read port and lane drop bus between the sequencer and its neighbours.
interface chart_sequencer_if #(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned ADDR_W    = 12
);
    logic [ADDR_W-1:0]      chart_addr;
    logic [2*NUM_LANES:0]   chart_data;
    logic                   scroll_tick;
    logic [2*NUM_LANES-1:0] drop_note;

    modport master (
        output chart_addr,
        output scroll_tick,
        output drop_note,
        input  chart_data
    );

    modport slave (
        input  chart_addr,
        input  scroll_tick,
        input  drop_note,
        output chart_data
    );
endinterface

// File: rtl/chart_sequencer_scroll_timer.sv
// Scroll step divider: counts 0..TICK_DIV-1 while enabled, flags the last count.
module scroll_timer #(
    parameter int unsigned TICK_DIV = 400000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST);
endmodule

// File: rtl/chart_sequencer.sv
// Plays a chart from ROM into the note lanes: prefetches one word per scroll step,
// emits sanitised drop codes with a scroll strobe, and drains the lanes at song end.
module chart_sequencer
    import gfx_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 5,
    parameter int unsigned TICK_DIV    = 400000,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DRAIN_STEPS = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause_toggle,
    input  logic              abort,
    chart_sequencer_if.master bus,
    output logic              song_active,
    output logic              song_done,
    output logic [ADDR_W-1:0] step_count
);
    localparam int unsigned WORD_W  = 2 * NUM_LANES + 1;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_STEPS + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_STEPS);

    seq_state_t state, state_next;

    logic                      prime_second;
    logic [WORD_W-1:0]         prefetch;
    logic [ADDR_W-1:0]         pf_addr;
    logic [DRAIN_W-1:0]        drain_cnt;
    logic [NUM_LANES-1:0][1:0] lane_codes;
    logic                      tc;
    logic                      timer_en;
    logic                      timer_clr;
    logic                      fire;
    logic                      go_prime;
    logic                      capture;
    logic                      chart_end;

    scroll_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en),
        .clr   (timer_clr),
        .tc    (tc)
    );

    // pf_addr tracks the ROM address the prefetched word came from.
    assign chart_end = prefetch[WORD_W-1] || (pf_addr == '1);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_codes[k] = chart_lane_code(MAX_WORD_W'(prefetch), k);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A resume from PAUSED counts as a running cycle, so a tick frozen at
    // terminal count fires on the resume edge.
    always_comb begin
        state_next = state;
        timer_en   = 1'b0;
        timer_clr  = 1'b0;
        fire       = 1'b0;
        go_prime   = 1'b0;
        capture    = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
            timer_clr  = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next = S_PRIME;
                        go_prime   = 1'b1;
                        timer_clr  = 1'b1;
                    end
                end
                S_PRIME: begin
                    if (prime_second) begin
                        state_next = S_PLAY;
                        capture    = 1'b1;
                        timer_clr  = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (pause_toggle) begin
                        state_next = S_PAUSED;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (pause_toggle) begin
                        state_next = S_PLAY;
                        timer_en   = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.scroll_tick && drain_cnt == DRAIN_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
            fire = timer_en && tc;
            if (fire && state != S_DRAIN && chart_end) begin
                state_next = S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.chart_addr  <= '0;
            bus.scroll_tick <= 1'b0;
            bus.drop_note   <= '0;
            song_active     <= 1'b0;
            song_done       <= 1'b0;
            step_count      <= '0;
            prime_second    <= 1'b0;
            prefetch        <= '0;
            pf_addr         <= '0;
            drain_cnt       <= '0;
        end else begin
            bus.scroll_tick <= fire;
            bus.drop_note   <= '0;
            song_active     <= (state_next == S_PRIME) || (state_next == S_PLAY) ||
                               (state_next == S_PAUSED) || (state_next == S_DRAIN);
            song_done       <= (state_next == S_DONE);
            prime_second    <= (state == S_PRIME) && (state_next == S_PRIME);
            if (abort) begin
                bus.chart_addr <= '0;
                step_count     <= '0;
                prefetch       <= '0;
                pf_addr        <= '0;
                drain_cnt      <= '0;
            end else begin
                if (go_prime) begin
                    bus.chart_addr <= '0;
                    step_count     <= '0;
                    drain_cnt      <= '0;
                end
                if (capture) begin
                    prefetch       <= bus.chart_data;
                    pf_addr        <= '0;
                    bus.chart_addr <= ADDR_W'(1);
                end
                if (fire && state != S_DRAIN) begin
                    bus.drop_note <= lane_codes;
                    if (step_count != '1) begin
                        step_count <= step_count + 1'b1;
                    end
                    if (bus.chart_addr != '1) begin
                        bus.chart_addr <= bus.chart_addr + 1'b1;
                    end
                end
                if (fire && state == S_DRAIN) begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                // ROM data lags the address by one cycle, so reload after the tick.
                if (bus.scroll_tick && state == S_PLAY) begin
                    prefetch <= bus.chart_data;
                    pf_addr  <= pf_addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer against a step/tick-count reference model.
module tb_chart_sequencer;
    localparam int unsigned NUM_LANES   = 5;
    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned DRAIN_STEPS = 96;
    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam int unsigned WORD_W      = 2 * NUM_LANES + 1;

    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2, M_PAUSED = 3, M_DRAIN = 4, M_DONE = 5;

    logic clk = 1'b0;
    logic rst_n, start, pause_toggle, abort;
    logic song_active, song_done;
    logic [ADDR_W-1:0] step_count;
    logic [WORD_W-1:0] rom [DEPTH];

    int n_checks = 0;
    int n_pass = 0;
    string phase = "init";

    int m_mode, m_prime_left, m_elapsed, m_emitted, m_drained, m_words;
    logic m_tick;
    logic [2*NUM_LANES-1:0] m_drop;

    chart_sequencer_if #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W)) bus ();

    chart_sequencer #(
        .NUM_LANES   (NUM_LANES),
        .TICK_DIV    (TICK_DIV),
        .ADDR_W      (ADDR_W),
        .DRAIN_STEPS (DRAIN_STEPS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause_toggle (pause_toggle),
        .abort        (abort),
        .bus          (bus),
        .song_active  (song_active),
        .song_done    (song_done),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.chart_data <= rom[bus.chart_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    endtask

    function automatic logic [2*NUM_LANES-1:0] sanitize(input logic [WORD_W-1:0] w);
        logic [2*NUM_LANES-1:0] r;
        logic [2*NUM_LANES-1:0] m;
        r = w[2*NUM_LANES-1:0];
        for (int k = 0; k < NUM_LANES; k++) begin
            m = (2*NUM_LANES)'(3) << (2 * k);
            if ((r & m) == m) r = r & ~m;
        end
        return r;
    endfunction

    function automatic int chart_len();
        for (int i = 0; i < DEPTH; i++) begin
            if (rom[i][WORD_W-1]) return i + 1;
        end
        return DEPTH;
    endfunction

    task automatic advance();
        m_elapsed++;
        if (m_elapsed % TICK_DIV == 0) begin
            m_tick = 1'b1;
            if (m_mode == M_DRAIN) begin
                m_drained++;
            end else begin
                m_drop = sanitize(rom[m_emitted]);
                m_emitted++;
                if (m_emitted == m_words) m_mode = M_DRAIN;
            end
        end
    endtask

    task automatic model_edge(input logic s, input logic p, input logic a);
        m_tick = 1'b0;
        m_drop = '0;
        if (a) begin
            m_mode = M_IDLE;
            m_emitted = 0;
            m_drained = 0;
            m_elapsed = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (s) begin
                    m_mode = M_PRIME;
                    m_prime_left = 2;
                    m_emitted = 0;
                    m_drained = 0;
                    m_words = chart_len();
                end
                M_PRIME: begin
                    m_prime_left--;
                    if (m_prime_left == 0) begin
                        m_mode = M_PLAY;
                        m_elapsed = 0;
                    end
                end
                M_PLAY: if (p) m_mode = M_PAUSED; else advance();
                M_PAUSED: if (p) begin
                    m_mode = M_PLAY;
                    advance();
                end
                M_DRAIN: if (m_drained == DRAIN_STEPS) m_mode = M_DONE; else advance();
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        int a;
        int st;
        a = (m_mode == M_IDLE || m_mode == M_PRIME) ? 0 : m_emitted + 1;
        if (a > DEPTH - 1) a = DEPTH - 1;
        st = (m_emitted > DEPTH - 1) ? DEPTH - 1 : m_emitted;
        chk("scroll_tick", 32'(bus.scroll_tick), 32'(m_tick));
        chk("drop_note", 32'(bus.drop_note), 32'(m_drop));
        chk("chart_addr", 32'(bus.chart_addr), 32'(a));
        chk("step_count", 32'(step_count), 32'(st));
        chk("song_active", 32'(song_active), 32'(m_mode >= M_PRIME && m_mode <= M_DRAIN));
        chk("song_done", 32'(song_done), 32'(m_mode == M_DONE));
    endtask

    task automatic step(input logic s, input logic p, input logic a);
        start = s;
        pause_toggle = p;
        abort = a;
        @(posedge clk);
        model_edge(s, p, a);
        #1;
        start = 1'b0;
        pause_toggle = 1'b0;
        abort = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pause_toggle = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_mode = M_IDLE;
        m_emitted = 0;
        m_drained = 0;
        m_elapsed = 0;
        m_tick = 1'b0;
        m_drop = '0;
        rst_n = 1'b1;
        check_outputs();
    endtask

    task automatic run_to_done(input string tag);
        for (int c = 0; c < 3000 && m_mode != M_DONE; c++) step(1'b0, 1'b0, 1'b0);
        chk(tag, 32'(song_done), 32'(1));
    endtask

    task automatic fill_random(input bit allow_end);
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = WORD_W'($urandom);
            if (!allow_end || $urandom_range(0, 5) != 0) rom[i][WORD_W-1] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        phase = "reset";
        do_reset();

        phase = "t1_basic";
        rom[0] = 11'h002;
        rom[1] = 11'h004;
        rom[2] = 11'h600;
        step(1'b1, 1'b0, 1'b0);
        run_to_done("done");
        chk("final_step_count", 32'(step_count), 32'(3));
        chk("final_chart_addr", 32'(bus.chart_addr), 32'(4));

        phase = "t2_invalid_code";
        fill_random(1'b0);
        rom[0] = rom[0] | 11'h030;
        rom[2][WORD_W-1] = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        run_to_done("done");

        phase = "t3_pause_at_tc";
        fill_random(1'b0);
        rom[4][WORD_W-1] = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && !(m_mode == M_PLAY && m_emitted == 1 &&
                                     m_elapsed % TICK_DIV == TICK_DIV - 1); c++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("pause_suppress", 32'(bus.scroll_tick), 32'(0));
        repeat (20) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("resume_tick", 32'(bus.scroll_tick), 32'(1));
        chk("resume_word", 32'(bus.drop_note), 32'(sanitize(rom[1])));
        run_to_done("done");

        phase = "t4_abort_drain";
        fill_random(1'b0);
        rom[1][WORD_W-1] = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1000 && !(m_mode == M_DRAIN && m_drained == 10); c++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("abort_active", 32'(song_active), 32'(0));
        chk("abort_addr", 32'(bus.chart_addr), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        run_to_done("replay_done");

        phase = "t5_no_end_marker";
        fill_random(1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_to_done("done");
        chk("sat_step_count", 32'(step_count), 32'(DEPTH - 1));

        phase = "t6_start_priority";
        step(1'b0, 1'b0, 1'b1);
        fill_random(1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 200 && m_emitted < 1; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_to_done("done");

        phase = "t7_mid_song_reset";
        fill_random(1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && m_emitted < 2; c++) step(1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        run_to_done("done");

        phase = "random";
        for (int s = 0; s < 4; s++) begin
            fill_random(1'b1);
            step(1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 6000 && m_mode != M_DONE; c++) begin
                step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, 1'b0);
            end
            chk("done", 32'(song_done), 32'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
